// File: rtl/riscv_single_cycle_cpu.sv
// Single-cycle RV32I-subset CPU: fetch, decode, execute and retire one instruction per clk.
// Top contains PC, instruction memory, register file, ALU and data memory; only clk/reset pins.

module riscv_imem #(
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);
  reg [31:0] memory [0:WORDS-1];

  // Program image normally arrives hierarchically; the load port is tied off at the top.
  always_ff @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign rdata = memory[addr];
endmodule

module riscv_dmem #(
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  reg [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];

  task automatic print_memory();
    for (int i = 0; i < int'(WORDS); i++) $display("%0d: %08h", i, memory[i]);
  endtask
endmodule

module riscv_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  reg [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is hardwired to zero on both read ports.
  assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : regs[raddr2];

  task automatic print_registers();
    for (int i = 0; i < 32; i++) $display("x%0d: %08h", i, regs[i]);
  endtask
endmodule

module riscv_single_cycle_cpu #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic        rf_we;
  logic        mem_we;
  logic        br_taken;
  logic        unused_addr_bits;

  riscv_imem #(.WORDS(IMEM_WORDS)) imem (
    .clk       (clk),
    .addr      (pc[IAW+1:2]),
    .rdata     (instr),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (32'h0)
  );

  riscv_regfile rf (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we & ~reset),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  riscv_dmem #(.WORDS(DMEM_WORDS)) dmem (
    .clk   (clk),
    .we    (mem_we & ~reset),
    .addr  (mem_addr[DAW+1:2]),
    .wdata (rs2_val),
    .rdata (mem_rdata)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'h000};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // Word addressing: byte offset and bits above the memory depth are dropped (wrap).
  assign mem_addr         = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (f3)
      3'b000: r = alt ? (a - b) : (a + b);
      3'b001: r = a << b[4:0];
      3'b010: r = {31'h0, $signed(a) < $signed(b)};
      3'b011: r = {31'h0, a < b};
      3'b100: r = a ^ b;
      3'b101: r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_val == rs2_val);
      3'b001: br_taken = (rs1_val != rs2_val);
      3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: br_taken = (rs1_val <  rs2_val);
      3'b111: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Decode/execute; any encoding not matched below retires as a NOP.
  always_comb begin
    next_pc = pc_plus4;
    wb_data = 32'h0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          rf_we   = 1'b1;
          wb_data = alu(funct3, funct7[5], rs1_val, rs2_val);
        end
      end
      OP_IMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == 7'h00 ||
            (funct3 == 3'b101 && funct7 == 7'h20)) begin
          rf_we   = 1'b1;
          wb_data = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_val, imm_i);
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we   = 1'b1;
          wb_data = mem_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) mem_we = 1'b1;
      end
      OP_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          rf_we   = 1'b1;
          wb_data = pc_plus4;
          next_pc = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_LUI: begin
        rf_we   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        rf_we   = 1'b1;
        wb_data = pc + imm_u;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= next_pc;
  end
endmodule

// File: tb/tb_riscv_single_cycle_cpu.sv
// Bench for riscv_single_cycle_cpu: directed programs plus random programs checked
// against an instruction-level model that executes symbolic (un-encoded) instructions.

module tb_riscv_single_cycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  riscv_single_cycle_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset)
  );

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_XOR = 4, K_SLL = 5,
                 K_SRL = 6, K_SRA = 7, K_SLT = 8, K_SLTU = 9;
  localparam int K_ADDI = 10, K_ANDI = 11, K_ORI = 12, K_XORI = 13, K_SLTI = 14,
                 K_SLTIU = 15, K_SLLI = 16, K_SRLI = 17, K_SRAI = 18;
  localparam int K_LW = 19, K_SW = 20, K_BEQ = 21, K_BNE = 22, K_BLT = 23, K_BGE = 24,
                 K_BLTU = 25, K_BGEU = 26, K_JAL = 27, K_LUI = 28, K_AUIPC = 29;
  localparam int K_JALR = 30, K_MUL = 31, K_ILL = 32;

  typedef struct {
    int kind;
    int rd;
    int rs1;
    int rs2;
    int imm;
  } instr_t;

  instr_t      prog [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, instr_t t);
    return {f7, 5'(t.rs2), 5'(t.rs1), f3, 5'(t.rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(logic [2:0] f3, logic [6:0] op, instr_t t);
    logic [31:0] im = 32'(t.imm);
    return {im[11:0], 5'(t.rs1), f3, 5'(t.rd), op};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3, instr_t t);
    logic [31:0] im = 32'(t.imm);
    return {im[12], im[10:5], 5'(t.rs2), 5'(t.rs1), f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] encode(instr_t t);
    logic [31:0] im = 32'(t.imm);
    case (t.kind)
      K_ADD:   return enc_r(7'h00, 3'b000, t);
      K_SUB:   return enc_r(7'h20, 3'b000, t);
      K_SLL:   return enc_r(7'h00, 3'b001, t);
      K_SLT:   return enc_r(7'h00, 3'b010, t);
      K_SLTU:  return enc_r(7'h00, 3'b011, t);
      K_XOR:   return enc_r(7'h00, 3'b100, t);
      K_SRL:   return enc_r(7'h00, 3'b101, t);
      K_SRA:   return enc_r(7'h20, 3'b101, t);
      K_OR:    return enc_r(7'h00, 3'b110, t);
      K_AND:   return enc_r(7'h00, 3'b111, t);
      K_MUL:   return enc_r(7'h01, 3'b000, t);
      K_ADDI:  return enc_i(3'b000, 7'h13, t);
      K_SLTI:  return enc_i(3'b010, 7'h13, t);
      K_SLTIU: return enc_i(3'b011, 7'h13, t);
      K_XORI:  return enc_i(3'b100, 7'h13, t);
      K_ORI:   return enc_i(3'b110, 7'h13, t);
      K_ANDI:  return enc_i(3'b111, 7'h13, t);
      K_SLLI:  return {7'h00, im[4:0], 5'(t.rs1), 3'b001, 5'(t.rd), 7'h13};
      K_SRLI:  return {7'h00, im[4:0], 5'(t.rs1), 3'b101, 5'(t.rd), 7'h13};
      K_SRAI:  return {7'h20, im[4:0], 5'(t.rs1), 3'b101, 5'(t.rd), 7'h13};
      K_LW:    return enc_i(3'b010, 7'h03, t);
      K_JALR:  return enc_i(3'b000, 7'h67, t);
      K_SW:    return {im[11:5], 5'(t.rs2), 5'(t.rs1), 3'b010, im[4:0], 7'h23};
      K_BEQ:   return enc_b(3'b000, t);
      K_BNE:   return enc_b(3'b001, t);
      K_BLT:   return enc_b(3'b100, t);
      K_BGE:   return enc_b(3'b101, t);
      K_BLTU:  return enc_b(3'b110, t);
      K_BGEU:  return enc_b(3'b111, t);
      K_JAL:   return {im[20], im[10:1], im[11], im[19:12], 5'(t.rd), 7'h6F};
      K_LUI:   return {im[19:0], 5'(t.rd), 7'h37};
      K_AUIPC: return {im[19:0], 5'(t.rd), 7'h17};
      default: return {20'h0, 5'(t.rd), 7'h00};
    endcase
  endfunction

  function automatic logic [31:0] rv(int r);
    return (r == 0) ? 32'h0 : m_regs[r];
  endfunction

  // Architectural model: executes one symbolic instruction with plain arithmetic.
  task automatic model_step();
    instr_t      t   = prog[8'(m_pc >> 2)];
    logic [31:0] a   = rv(t.rs1);
    logic [31:0] b   = rv(t.rs2);
    logic [31:0] iv  = 32'(t.imm);
    logic [31:0] res = 32'h0;
    logic [31:0] npc = m_pc + 32'd4;
    bit          wr  = 1'b1;
    case (t.kind)
      K_ADD:   res = a + b;
      K_SUB:   res = a - b;
      K_AND:   res = a & b;
      K_OR:    res = a | b;
      K_XOR:   res = a ^ b;
      K_SLL:   res = a << (b % 32);
      K_SRL:   res = a >> (b % 32);
      K_SRA:   res = 32'($signed(a) >>> (b % 32));
      K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
      K_ADDI:  res = a + iv;
      K_ANDI:  res = a & iv;
      K_ORI:   res = a | iv;
      K_XORI:  res = a ^ iv;
      K_SLTI:  res = ($signed(a) < $signed(iv)) ? 32'd1 : 32'd0;
      K_SLTIU: res = (a < iv) ? 32'd1 : 32'd0;
      K_SLLI:  res = a << t.imm;
      K_SRLI:  res = a >> t.imm;
      K_SRAI:  res = 32'($signed(a) >>> t.imm);
      K_LW:    res = m_mem[8'((a + iv) >> 2)];
      K_SW:    begin m_mem[8'((a + iv) >> 2)] = b; wr = 1'b0; end
      K_BEQ:   begin wr = 1'b0; if (a == b) npc = m_pc + iv; end
      K_BNE:   begin wr = 1'b0; if (a != b) npc = m_pc + iv; end
      K_BLT:   begin wr = 1'b0; if ($signed(a) < $signed(b)) npc = m_pc + iv; end
      K_BGE:   begin wr = 1'b0; if ($signed(a) >= $signed(b)) npc = m_pc + iv; end
      K_BLTU:  begin wr = 1'b0; if (a < b) npc = m_pc + iv; end
      K_BGEU:  begin wr = 1'b0; if (a >= b) npc = m_pc + iv; end
      K_JAL:   begin res = m_pc + 32'd4; npc = m_pc + iv; end
      K_JALR:  begin res = m_pc + 32'd4; npc = (a + iv) & 32'hFFFF_FFFE; end
      K_LUI:   res = iv * 32'd4096;
      K_AUIPC: res = m_pc + iv * 32'd4096;
      default: wr = 1'b0;
    endcase
    if (wr && t.rd != 0) m_regs[t.rd] = res;
    m_pc = npc;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic compare_state(string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s x%0d", tag, i), dut.rf.regs[i], m_regs[i]);
    for (int i = 0; i < 256; i++) check($sformatf("%s dmem[%0d]", tag, i), dut.dmem.memory[i], m_mem[i]);
    check({tag, " pc"}, dut.pc, m_pc);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '{K_ADDI, 0, 0, 0, 0};
  endtask

  task automatic put(int idx, int kind, int rd, int rs1, int rs2, int imm);
    prog[idx] = '{kind, rd, rs1, rs2, imm};
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Hold reset, load both images while the core is held, then release.
  task automatic start();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      dut.imem.memory[i] = encode(prog[i]);
      dut.dmem.memory[i] = m_mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run(int n, string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      model_step();
      check($sformatf("%s pc@%0d", tag, c), dut.pc, m_pc);
    end
  endtask

  initial begin
    // Reset: junk registers, a store at PC 0 that must not commit while reset is held.
    clear_prog();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_mem[0] = 32'h0000_002A;
    put(0, K_SW, 0, 0, 5, 4);
    for (int i = 0; i < 256; i++) begin
      dut.imem.memory[i] = encode(prog[i]);
      dut.dmem.memory[i] = m_mem[i];
    end
    for (int i = 0; i < 32; i++) dut.rf.regs[i] = $urandom | 32'h1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_state("reset");
    check("reset dmem0", dut.dmem.memory[0], 32'h0000_002A);
    check("reset dmem1", dut.dmem.memory[1], 32'h0);
    check("reset pc0", dut.pc, 32'h0);

    // ALU basics.
    clear_prog();
    put(0, K_ADDI, 1, 0, 0, 5);
    put(1, K_ADDI, 2, 0, 0, -3);
    put(2, K_ADD, 3, 1, 2, 0);
    put(3, K_SUB, 4, 1, 2, 0);
    start();
    run(4, "alu");
    compare_state("alu");
    check("alu x1", dut.rf.regs[1], 32'd5);
    check("alu x2", dut.rf.regs[2], 32'hFFFF_FFFD);
    check("alu x3", dut.rf.regs[3], 32'd2);
    check("alu x4", dut.rf.regs[4], 32'd8);

    // Load / store round trip.
    clear_prog();
    put(0, K_LW, 5, 0, 0, 0);
    put(1, K_SW, 0, 0, 5, 8);
    put(2, K_LW, 6, 0, 0, 8);
    start();
    run(3, "mem");
    compare_state("mem");
    check("mem x5", dut.rf.regs[5], 32'h2A);
    check("mem x6", dut.rf.regs[6], 32'h2A);
    check("mem dmem2", dut.dmem.memory[2], 32'h2A);

    // Reset asserted on the edge that would commit a store: nothing commits.
    m_mem[2] = 32'h0;
    start();
    run(1, "midrst");
    check("midrst x5 before", dut.rf.regs[5], 32'h2A);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("midrst pc", dut.pc, 32'h0);
    check("midrst x5", dut.rf.regs[5], 32'h0);
    check("midrst dmem2", dut.dmem.memory[2], 32'h0);
    run(2, "midrst");
    check("midrst dmem2 after", dut.dmem.memory[2], 32'h2A);

    // Countdown loop: three iterations of ADDI/BNE, then falls through to PC 0xC.
    clear_prog();
    put(0, K_ADDI, 1, 0, 0, 3);
    put(1, K_ADDI, 1, 1, 0, -1);
    put(2, K_BNE, 0, 1, 0, -4);
    start();
    run(6, "loop");
    check("loop pc@6", dut.pc, 32'h8);
    run(1, "loop");
    check("loop exit pc", dut.pc, 32'hC);
    check("loop x1", dut.rf.regs[1], 32'h0);

    // JAL / JALR.
    clear_prog();
    put(4, K_JAL, 1, 0, 0, 8);
    put(6, K_JALR, 0, 1, 0, 0);
    start();
    run(5, "jal");
    check("jal x1", dut.rf.regs[1], 32'h14);
    check("jal pc", dut.pc, 32'h18);
    run(1, "jalr");
    check("jalr pc", dut.pc, 32'h14);
    check("jalr x0", dut.rf.regs[0], 32'h0);

    // x0 writes, signed vs unsigned compare, LUI, unsupported encodings as NOPs.
    clear_prog();
    put(0, K_ADDI, 0, 0, 0, 7);
    put(1, K_ADDI, 1, 0, 0, -1);
    put(2, K_ADDI, 2, 0, 0, 1);
    put(3, K_SLT, 3, 1, 2, 0);
    put(4, K_SLTU, 4, 1, 2, 0);
    put(5, K_LUI, 7, 0, 0, 32'h12345);
    put(6, K_ADDI, 6, 0, 0, 9);
    put(7, K_MUL, 6, 1, 2, 0);
    put(8, K_ILL, 6, 0, 0, 0);
    start();
    run(9, "misc");
    compare_state("misc");
    check("misc x0", dut.rf.regs[0], 32'h0);
    check("misc slt", dut.rf.regs[3], 32'h1);
    check("misc sltu", dut.rf.regs[4], 32'h0);
    check("misc lui", dut.rf.regs[7], 32'h1234_5000);
    check("misc nop x6", dut.rf.regs[6], 32'd9);

    // Random straight-line programs with forward branches/jumps.
    for (int r = 0; r < 4; r++) begin
      clear_prog();
      for (int i = 0; i < 256; i++) m_mem[i] = $urandom;
      for (int i = 0; i < 48; i++) begin
        int k;
        int imm;
        k = int'($urandom_range(0, K_AUIPC));
        if (k >= K_ADDI && k <= K_SLTIU)      imm = int'($urandom_range(0, 4095)) - 2048;
        else if (k >= K_SLLI && k <= K_SRAI)  imm = int'($urandom_range(0, 31));
        else if (k == K_LW || k == K_SW)      imm = int'($urandom_range(0, 255)) - 128;
        else if (k >= K_BEQ && k <= K_JAL)    imm = 4 * int'($urandom_range(1, 4));
        else if (k == K_LUI || k == K_AUIPC)  imm = int'($urandom_range(0, 32'hFFFFF));
        else                                  imm = 0;
        put(i, k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), imm);
      end
      start();
      run(60, $sformatf("rand%0d", r));
      compare_state($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
